// File: rtl/n_serial_loader.sv
// Serial-to-parallel front end: assembles WIDTH-bit words from a qualified bit
// stream and emits each word with a one-cycle load strobe; stalled frames time out.
module n_serial_loader #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   parameter int TIMEOUT   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     io_bitIn,
   input  logic                     io_bitValid,
   input  logic                     io_clear,
   output logic [WIDTH-1:0]         io_D,
   output logic                     io_enable,
   output logic [$clog2(WIDTH):0]   io_count,
   output logic                     io_error
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [TW-1:0]    idle_q, idle_d;
   logic             en_q, en_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] shifted;

   // Bit order is fixed at elaboration: the first bit ends up at the MSB or LSB.
   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign shifted = {shift_q[WIDTH-2:0], io_bitIn};
      end else begin : g_lsb_first
         assign shifted = {io_bitIn, shift_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      shift_d = shift_q;
      word_d  = word_q;
      idle_d  = idle_q;
      en_d    = 1'b0;
      err_d   = 1'b0;
      if (io_clear) begin
         state_d = S_IDLE;
         count_d = '0;
         shift_d = '0;
         idle_d  = '0;
      end else if (io_bitValid) begin
         idle_d = '0;
         if (state_q == S_SHIFT && count_q == CW'(WIDTH - 1)) begin
            state_d = S_IDLE;
            count_d = '0;
            shift_d = '0;
            word_d  = shifted;
            en_d    = 1'b1;
         end else begin
            state_d = S_SHIFT;
            count_d = count_q + CW'(1);
            shift_d = shifted;
         end
      end else if (state_q == S_SHIFT) begin
         // The edge on which the counter would reach TIMEOUT drops the frame.
         if (idle_q == TW'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            count_d = '0;
            shift_d = '0;
            idle_d  = '0;
            err_d   = 1'b1;
         end else begin
            idle_d = idle_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         shift_q <= '0;
         word_q  <= '0;
         idle_q  <= '0;
         en_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         idle_q  <= idle_d;
         en_q    <= en_d;
         err_q   <= err_d;
      end
   end

   assign io_D      = word_q;
   assign io_enable = en_q;
   assign io_count  = count_q;
   assign io_error  = err_q;

endmodule

// File: tb/tb_n_serial_loader.sv
// Scoreboard bench: stimulus pushes expected words/errors, monitors pop on strobes.
`timescale 1ns/1ps
module tb_n_serial_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       bit_in, bit_valid, clear;
   logic [7:0] d_m, d_l;
   logic       en_m, en_l, err_m, err_l;
   logic [3:0] cnt_m, cnt_l;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_m[$];
   logic [7:0] exp_l[$];
   bit         experr_m[$];
   bit         experr_l[$];

   logic [7:0] reg_q;
   logic [7:0] last_m;
   logic       prev_en_m = 1'b0;
   logic       prev_en_l = 1'b0;

   always #5 clk = ~clk;

   n_serial_loader #(.WIDTH(8), .MSB_FIRST(1), .TIMEOUT(16)) dut_m (
      .clk(clk), .reset(reset), .io_bitIn(bit_in), .io_bitValid(bit_valid),
      .io_clear(clear), .io_D(d_m), .io_enable(en_m), .io_count(cnt_m), .io_error(err_m)
   );

   n_serial_loader #(.WIDTH(8), .MSB_FIRST(0), .TIMEOUT(16)) dut_l (
      .clk(clk), .reset(reset), .io_bitIn(bit_in), .io_bitValid(bit_valid),
      .io_clear(clear), .io_D(d_l), .io_enable(en_l), .io_count(cnt_l), .io_error(err_l)
   );

   // Downstream NRegisterE stand-in fed by the MSB-first loader.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     reg_q <= 8'h00;
      else if (en_m) reg_q <= d_m;
   end

   always @(negedge clk) begin
      if (prev_en_m) begin
         checks++;
         if (reg_q !== last_m) begin
            errors++;
            $display("FAIL nreg_q got=%h want=%h", reg_q, last_m);
         end
      end
      if (en_m) begin
         checks++;
         if (prev_en_m) begin
            errors++;
            $display("FAIL strobe_m back-to-back io_D=%h", d_m);
         end else if (exp_m.size() == 0) begin
            errors++;
            $display("FAIL strobe_m unexpected io_D=%h", d_m);
         end else begin
            last_m = exp_m.pop_front();
            if (d_m !== last_m) begin
               errors++;
               $display("FAIL word_m got=%h want=%h", d_m, last_m);
            end else $display("word_m io_D=%h ok", d_m);
         end
      end
      if (err_m) begin
         checks++;
         if (experr_m.size() == 0) begin
            errors++;
            $display("FAIL error_m unexpected pulse");
         end else begin
            void'(experr_m.pop_front());
            $display("error_m pulse ok");
         end
      end
      prev_en_m = en_m;
   end

   always @(negedge clk) begin
      if (en_l) begin
         checks++;
         if (prev_en_l) begin
            errors++;
            $display("FAIL strobe_l back-to-back io_D=%h", d_l);
         end else if (exp_l.size() == 0) begin
            errors++;
            $display("FAIL strobe_l unexpected io_D=%h", d_l);
         end else begin
            logic [7:0] w;
            w = exp_l.pop_front();
            if (d_l !== w) begin
               errors++;
               $display("FAIL word_l got=%h want=%h", d_l, w);
            end else $display("word_l io_D=%h ok", d_l);
         end
      end
      if (err_l) begin
         checks++;
         if (experr_l.size() == 0) begin
            errors++;
            $display("FAIL error_l unexpected pulse");
         end else begin
            void'(experr_l.pop_front());
            $display("error_l pulse ok");
         end
      end
      prev_en_l = en_l;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end else $display("%s = %0h ok", name, got);
   endtask

   task automatic send_bit(input logic b);
      bit_in    = b;
      bit_valid = 1'b1;
      @(posedge clk); #1;
      bit_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Bits go out in order w[7] .. w[0], with 'gap' idle cycles between them.
   task automatic send_word(input logic [7:0] w, input int gap);
      for (int i = 7; i >= 0; i--) begin
         send_bit(w[i]);
         if (i > 0) idle(gap);
      end
   endtask

   task automatic push(input logic [7:0] wm, input logic [7:0] wl);
      exp_m.push_back(wm);
      exp_l.push_back(wl);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a5;
      reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0;
      idle(2);
      check("rst_io_D", {24'h0, d_m}, 32'h0);
      check("rst_io_enable", {31'h0, en_m}, 32'h0);
      check("rst_io_count", {28'h0, cnt_m}, 32'h0);
      check("rst_io_error", {31'h0, err_m}, 32'h0);
      reset = 1'b0;
      idle(2);

      // 1: A5 MSB-first, io_count walks 1..7 then 0
      push(8'hA5, 8'hA5);
      a5 = 8'hA5;
      for (int k = 0; k < 8; k++) begin
         send_bit(a5[7-k]);
         check($sformatf("t1_count_%0d", k), {28'h0, cnt_m}, (k < 7) ? k + 1 : 0);
      end
      idle(3);

      // 2: bits 1,1,0,0,0,0,0,0 -> C0 MSB-first, 03 LSB-first
      push(8'hC0, 8'h03);
      send_word(8'hC0, 0);
      idle(3);

      // 3: timeout after 3 bits and 16 idle cycles
      experr_m.push_back(1'b1);
      experr_l.push_back(1'b1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      idle(15);
      check("t3_count_before", {28'h0, cnt_m}, 32'd3);
      idle(1);
      check("t3_count_after", {28'h0, cnt_m}, 32'd0);
      idle(2);
      check("t3_hold_D_m", {24'h0, d_m}, 32'hC0);
      check("t3_hold_D_l", {24'h0, d_l}, 32'h03);
      push(8'hFF, 8'hFF);
      send_word(8'hFF, 0);
      idle(3);

      // 4: clear with the 8th bit aborts the frame
      for (int i = 7; i >= 1; i--) send_bit(1'b1);
      check("t4_count_7", {28'h0, cnt_m}, 32'd7);
      clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; bit_valid = 1'b0;
      check("t4_count_clr", {28'h0, cnt_l}, 32'd0);
      idle(3);
      check("t4_hold_D", {24'h0, d_m}, 32'hFF);
      push(8'h3C, 8'h3C);
      send_word(8'h3C, 0);
      idle(3);

      // 5: reset mid-frame
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      reset = 1'b1;
      #1;
      check("t5_rst_D", {24'h0, d_m}, 32'h0);
      check("t5_rst_count", {28'h0, cnt_m}, 32'h0);
      idle(2);
      check("t5_rst_enable", {31'h0, en_m}, 32'h0);
      reset = 1'b0;
      idle(1);
      push(8'h81, 8'h81);
      send_word(8'h81, 0);
      idle(3);

      // 6: 15-cycle gaps never time out
      push(8'h5A, 8'h5A);
      send_word(8'h5A, 15);
      idle(3);
      check("t6_nreg_q", {24'h0, reg_q}, 32'h5A);

      check("pending_words_m", exp_m.size(), 32'd0);
      check("pending_words_l", exp_l.size(), 32'd0);
      check("pending_errs_m", experr_m.size(), 32'd0);
      check("pending_errs_l", experr_l.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
